// File: rtl/seg_scan_pkg.sv
// Shared constants and elaboration helpers for the seven-segment scanner.
// Provides the digit width, the anode-off pattern and the parameter legality check.
package seg_scan_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    // All anodes off: one bit set per populated digit, upper unused bits cleared.
    function automatic logic [MAX_DIGITS-1:0] anode_off(input int digits);
        logic [MAX_DIGITS-1:0] mask;
        mask = {MAX_DIGITS{1'b0}};
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = 1'b0;
            end
        end
        return mask;
    endfunction

    function automatic bit params_ok(input int digits, input int slot_cyc, input int guard_cyc);
        return (digits >= 2) && (digits <= MAX_DIGITS) &&
               (guard_cyc >= 0) && (slot_cyc >= guard_cyc + 1) && (slot_cyc >= 2);
    endfunction

endpackage

// File: rtl/seg_scan_lz_mask.sv
// Leading-zero blank mask: marks every digit above digit 0 that has only zeros
// at and above its own position, when suppression is enabled.
module lz_mask
    import seg_scan_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [DIGIT_W*DIGITS-1:0] dp_val,
    input  logic                      dp_lz,
    output logic [DIGITS-1:0]         blank
);

    logic [DIGITS-1:0] blank_s;
    logic              seen_nz_s;

    // Walk from the most significant digit down, tracking whether a non-zero digit was seen.
    always_comb begin
        blank_s   = {DIGITS{1'b0}};
        seen_nz_s = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen_nz_s = seen_nz_s | (|dp_val[i*DIGIT_W +: DIGIT_W]);
            if (dp_lz && (i != 0) && !seen_nz_s) begin
                blank_s[i] = 1'b1;
            end else begin
                blank_s[i] = 1'b0;
            end
        end
    end

    assign blank = blank_s;

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with double-buffered value
// updates at frame boundaries, guard blanking between slots and leading-zero suppression.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SLOT_CYC  = 50000,
    parameter int GUARD_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] value,
    input  logic                      lz_en,
    output logic                      pending,
    output logic [DIGIT_W-1:0]        nibble,
    output logic [DIGITS-1:0]         an,
    output logic                      frame
);

    localparam int VAL_W = DIGIT_W * DIGITS;
    localparam int CW    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int DW    = $clog2(DIGITS);
    localparam logic [MAX_DIGITS-1:0] AN_OFF_FULL = anode_off(DIGITS);
    localparam logic [DIGITS-1:0]     AN_OFF      = AN_OFF_FULL[DIGITS-1:0];

    if (!params_ok(DIGITS, SLOT_CYC, GUARD_CYC)) begin : g_param_check
        $error("seg_scan: illegal DIGITS/SLOT_CYC/GUARD_CYC combination");
    end

    logic [CW-1:0]        slot_cnt_r;
    logic [DW-1:0]        dig_r;
    logic [VAL_W-1:0]     sh_val_r;
    logic                 sh_lz_r;
    logic                 pending_r;
    logic [VAL_W-1:0]     dp_val_r;
    logic                 dp_lz_r;
    logic [DIGIT_W-1:0]   nibble_r;
    logic [DIGITS-1:0]    an_r;
    logic                 frame_r;

    logic                 slot_wrap_s;
    logic                 frame_end_s;
    logic [DIGITS-1:0]    blank_s;
    logic [DIGITS-1:0]    an_next_s;
    logic                 frame_next_s;

    lz_mask #(
        .DIGITS (DIGITS)
    ) u_lz_mask (
        .dp_val (dp_val_r),
        .dp_lz  (dp_lz_r),
        .blank  (blank_s)
    );

    // Slot/frame boundary decode and next output values from the current scan position.
    always_comb begin
        slot_wrap_s  = (slot_cnt_r == CW'(SLOT_CYC - 1));
        frame_end_s  = slot_wrap_s && (dig_r == DW'(DIGITS - 1));
        frame_next_s = (slot_cnt_r == {CW{1'b0}}) && (dig_r == {DW{1'b0}});
        an_next_s    = AN_OFF;
        if (slot_cnt_r < CW'(GUARD_CYC)) begin
            an_next_s = AN_OFF;
        end else if (blank_s[dig_r]) begin
            an_next_s = AN_OFF;
        end else begin
            an_next_s = AN_OFF & ~({{(DIGITS-1){1'b0}}, 1'b1} << dig_r);
        end
    end

    // Prescaler and digit index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_r <= {CW{1'b0}};
            dig_r      <= {DW{1'b0}};
        end else if (slot_wrap_s) begin
            slot_cnt_r <= {CW{1'b0}};
            if (dig_r == DW'(DIGITS - 1)) begin
                dig_r <= {DW{1'b0}};
            end else begin
                dig_r <= dig_r + DW'(1);
            end
        end else begin
            slot_cnt_r <= slot_cnt_r + CW'(1);
            dig_r      <= dig_r;
        end
    end

    // Shadow/display double buffer; a load coinciding with the boundary keeps pending set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_val_r  <= {VAL_W{1'b0}};
            sh_lz_r   <= 1'b0;
            pending_r <= 1'b0;
            dp_val_r  <= {VAL_W{1'b0}};
            dp_lz_r   <= 1'b0;
        end else begin
            if (frame_end_s && pending_r) begin
                dp_val_r <= sh_val_r;
                dp_lz_r  <= sh_lz_r;
            end
            if (load) begin
                sh_val_r  <= value;
                sh_lz_r   <= lz_en;
                pending_r <= 1'b1;
            end else if (frame_end_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Registered display outputs, one cycle behind the scan position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nibble_r <= {DIGIT_W{1'b0}};
            an_r     <= AN_OFF;
            frame_r  <= 1'b0;
        end else begin
            nibble_r <= dp_val_r[DIGIT_W*dig_r +: DIGIT_W];
            an_r     <= an_next_s;
            frame_r  <= frame_next_s;
        end
    end

    assign pending = pending_r;
    assign nibble  = nibble_r;
    assign an      = an_r;
    assign frame   = frame_r;

endmodule
